// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_IDX_W   = 2;

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module irq_priority_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing, maskable interrupt controller: one committed request at a
// time, held until acknowledged, then blocked until the handler returns.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               int_ack,
  input  logic               rti_done,
  output logic               interrupt,
  output logic [IDX_W-1:0]   int_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] src_clear
);

  irq_state_e         state, state_nx;
  logic [NUM_SRC-1:0] irq_src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [IDX_W-1:0]   int_id_nx;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;

  irq_priority_enc #(
    .NUM_SRC(NUM_SRC),
    .IDX_W  (IDX_W)
  ) u_enc (
    .req  (pending & ~irq_mask),
    .valid(sel_valid),
    .idx  (sel_idx)
  );

  assign rise       = irq_src & ~irq_src_q;
  assign interrupt  = (state == REQ);
  assign in_service = (state == SERVICE);

  always_comb begin
    state_nx  = state;
    int_id_nx = int_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nx  = REQ;
          int_id_nx = sel_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          clr      = NUM_SRC'(1) << int_id;
          state_nx = SERVICE;
        end
      end
      SERVICE: begin
        if (rti_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_id    <= '0;
      pending   <= '0;
      irq_src_q <= '0;
      src_clear <= '0;
    end else begin
      state     <= state_nx;
      int_id    <= int_id_nx;
      // a fresh edge on the source being cleared re-arms it
      pending   <= (pending & ~clr) | rise;
      irq_src_q <= irq_src;
      src_clear <= clr;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, monitor compares.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_src = '0;
  logic [3:0] irq_mask = '0;
  logic       int_ack = 1'b0;
  logic       rti_done = 1'b0;
  logic       interrupt;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] src_clear;

  interrupt_controller #(.NUM_SRC(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .irq_mask  (irq_mask),
    .int_ack   (int_ack),
    .rti_done  (rti_done),
    .interrupt (interrupt),
    .int_id    (int_id),
    .in_service(in_service),
    .pending   (pending),
    .src_clear (src_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       intr;
    logic [1:0] id;
    logic       svc;
    logic [3:0] pend;
    logic [3:0] clr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;

  // Reference model: set of outstanding requests, plus the handler phase.
  bit   req_set [4];
  bit   last_lvl [4];
  int   phase;        // 0 = nothing outstanding, 1 = asking core, 2 = handler running
  int   cur_id;
  logic [3:0] cur_src = '0;
  logic [3:0] cur_mask = '0;

  function automatic exp_t model_step();
    exp_t e;
    bit   served [4];
    for (int i = 0; i < 4; i++) served[i] = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        req_set[i]  = 1'b0;
        last_lvl[i] = 1'b0;
      end
      phase  = 0;
      cur_id = 0;
    end else begin
      if (phase == 0) begin
        for (int i = 3; i >= 0; i--)
          if (req_set[i] && !irq_mask[i]) begin
            cur_id = i;
            phase  = 1;
          end
      end else if (phase == 1) begin
        if (int_ack) begin
          served[cur_id] = 1'b1;
          phase = 2;
        end
      end else if (rti_done) begin
        phase = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (served[i]) req_set[i] = 1'b0;
        if (irq_src[i] && !last_lvl[i]) req_set[i] = 1'b1;
        last_lvl[i] = irq_src[i];
      end
    end
    e.intr = (phase == 1);
    e.svc  = (phase == 2);
    e.id   = 2'(cur_id);
    for (int i = 0; i < 4; i++) begin
      e.pend[i] = req_set[i];
      e.clr[i]  = served[i];
    end
    return e;
  endfunction

  task automatic drive(input logic [3:0] s, input logic [3:0] m,
                       input logic a, input logic r, input logic rs);
    @(negedge clk);
    irq_src  = s;
    irq_mask = m;
    int_ack  = a;
    rti_done = r;
    rst      = rs;
    cur_src  = s;
    cur_mask = m;
    q.push_back(model_step());
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(cur_src, cur_mask, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output word.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        g = '{interrupt, int_id, in_service, pending, src_clear};
        tests++;
        if (g !== e) begin
          failed++;
          $display("FAIL outputs@cyc%0d: got intr=%0b id=%0d svc=%0b pend=%b clr=%b, expected intr=%0b id=%0d svc=%0b pend=%b clr=%b",
                   cyc, g.intr, g.id, g.svc, g.pend, g.clr, e.intr, e.id, e.svc, e.pend, e.clr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // basic
    drive(4'b0000, 4'b0000, 0, 0, 1);
    drive(4'b0000, 4'b0000, 0, 0, 1);
    hold(2);
    drive(4'b0100, 4'b0000, 0, 0, 0);
    hold(3);
    drive(cur_src, cur_mask, 1, 0, 0);
    hold(4);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(2);
    // priority
    drive(4'b0000, 4'b0000, 0, 0, 0);
    drive(4'b1010, 4'b0000, 0, 0, 0);
    hold(3);
    drive(cur_src, cur_mask, 1, 0, 0);
    hold(2);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(2);
    drive(cur_src, cur_mask, 1, 0, 0);
    hold(1);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(1);
    // mask
    drive(4'b0000, 4'b0001, 0, 0, 0);
    drive(4'b0001, 4'b0001, 0, 0, 0);
    drive(4'b0000, 4'b0001, 0, 0, 0);
    hold(3);
    drive(4'b0000, 4'b0000, 0, 0, 0);
    hold(2);
    drive(cur_src, cur_mask, 1, 0, 0);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(1);
    // nesting blocked
    drive(4'b0100, 4'b0000, 0, 0, 0);
    hold(2);
    drive(cur_src, cur_mask, 1, 0, 0);
    drive(4'b1100, 4'b0000, 0, 0, 0);
    hold(3);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(3);
    drive(cur_src, cur_mask, 1, 0, 0);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(1);
    // spurious ack in IDLE, spurious rti in REQ, collision on id 1
    drive(4'b0000, 4'b0000, 1, 0, 0);
    drive(4'b0010, 4'b0000, 0, 0, 0);
    hold(2);
    drive(4'b0000, 4'b0000, 0, 1, 0);
    drive(4'b0010, 4'b0000, 1, 0, 0);
    hold(1);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(2);
    drive(cur_src, cur_mask, 1, 0, 0);
    drive(cur_src, cur_mask, 0, 1, 0);
    hold(1);
    // reset during SERVICE with pending 0110, source 1 held through release
    drive(4'b0000, 4'b0000, 0, 0, 0);
    drive(4'b0001, 4'b0000, 0, 0, 0);
    hold(2);
    drive(cur_src, cur_mask, 1, 0, 0);
    drive(4'b0111, 4'b0000, 0, 0, 0);
    hold(1);
    drive(4'b0010, 4'b0000, 0, 0, 1);
    hold(4);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] s;
      logic [3:0] m;
      s = cur_src;
      m = cur_mask;
      if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) m = 4'($urandom_range(0, 15));
      drive(s, m, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 99) == 0));
    end
    hold(2);
    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
